// File: rtl/oled_spi_sink_pkg.sv
// Shared opcodes, reset defaults and parser state for the OLED SPI sink model.
package oled_pkg;

   localparam logic [7:0] OP_DISPLAY_OFF  = 8'hAE;
   localparam logic [7:0] OP_DISPLAY_ON   = 8'hAF;
   localparam logic [7:0] OP_ENTIRE_OFF   = 8'hA4;
   localparam logic [7:0] OP_ENTIRE_ON    = 8'hA5;
   localparam logic [7:0] OP_NORMAL       = 8'hA6;
   localparam logic [7:0] OP_INVERT       = 8'hA7;
   localparam logic [7:0] OP_CONTRAST     = 8'h81;
   localparam logic [7:0] OP_ADDR_MODE    = 8'h20;
   localparam logic [7:0] OP_MUX_RATIO    = 8'hA8;
   localparam logic [7:0] OP_DISP_OFFSET  = 8'hD3;
   localparam logic [7:0] OP_CLK_DIV      = 8'hD5;
   localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
   localparam logic [7:0] OP_VCOMH        = 8'hDB;
   localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
   localparam logic [7:0] OP_COL_ADDR     = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR    = 8'h22;

   localparam logic [7:0] CONTRAST_DEFAULT = 8'h7F;

   typedef enum logic [1:0] {
      OP   = 2'd0,
      ARG1 = 2'd1,
      ARG2 = 2'd2
   } parse_state_e;

endpackage

// File: rtl/oled_spi_sink_spi_byte_rx.sv
// Synchronises the 4-wire OLED link into clk and assembles MSB-first bytes
// on rising io_sclk edges, tagging each with the dc level seen on bit 0.
module spi_byte_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_sclk,
   input  logic       io_sdin,
   input  logic       io_cs,
   input  logic       io_dc,
   input  logic       io_reset,
   output logic [7:0] data_byte,
   output logic       is_data,
   output logic       byte_valid,
   output logic       n_reset
);

   logic [SYNC_STAGES-1:0] sclk_q, sdin_q, cs_q, dc_q, nrst_q;
   logic       sclk_prev;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic       sclk_s, sdin_s, cs_s, dc_s, sclk_rise;

   assign sclk_s    = sclk_q[SYNC_STAGES-1];
   assign sdin_s    = sdin_q[SYNC_STAGES-1];
   assign cs_s      = cs_q[SYNC_STAGES-1];
   assign dc_s      = dc_q[SYNC_STAGES-1];
   assign n_reset   = nrst_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;

   // Idle-high lines reset high so leaving reset never looks like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q     <= '1;
         sdin_q     <= '0;
         cs_q       <= '1;
         dc_q       <= '0;
         nrst_q     <= '1;
         sclk_prev  <= 1'b1;
         bit_cnt    <= '0;
         shift      <= '0;
         data_byte  <= '0;
         is_data    <= 1'b0;
         byte_valid <= 1'b0;
      end else begin
         sclk_q     <= {sclk_q[SYNC_STAGES-2:0], io_sclk};
         sdin_q     <= {sdin_q[SYNC_STAGES-2:0], io_sdin};
         cs_q       <= {cs_q[SYNC_STAGES-2:0], io_cs};
         dc_q       <= {dc_q[SYNC_STAGES-2:0], io_dc};
         nrst_q     <= {nrst_q[SYNC_STAGES-2:0], io_reset};
         sclk_prev  <= sclk_s;
         byte_valid <= 1'b0;
         if (cs_s || !n_reset) begin
            bit_cnt <= '0;
         end else if (sclk_rise) begin
            if (bit_cnt == 3'd7) begin
               data_byte  <= {shift, sdin_s};
               is_data    <= dc_s;
               byte_valid <= 1'b1;
               bit_cnt    <= '0;
            end else begin
               shift   <= {shift[5:0], sdin_s};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/oled_spi_sink.sv
// SSD1306-style controller end of the OLED link: command parser, display state
// registers and the horizontal-addressing framebuffer write pointer.
//
// state | meaning
// OP    | next command byte is an opcode
// ARG1  | next command byte is the first argument of opcode
// ARG2  | next command byte is the second argument (0x21 / 0x22 only)
module oled_spi_sink
   import oled_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int COLS        = 128,
   parameter int PAGES       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_sclk,
   input  logic       io_sdin,
   input  logic       io_cs,
   input  logic       io_dc,
   input  logic       io_reset,
   output logic [9:0] fb_addr,
   output logic [7:0] fb_data,
   output logic       fb_we,
   output logic       frame_done,
   output logic       display_on,
   output logic [7:0] contrast,
   output logic       invert,
   output logic       entire_on,
   output logic       charge_pump
);

   localparam int CW = $clog2(COLS);
   localparam int PW = $clog2(PAGES);

   logic [7:0] rx_byte;
   logic       rx_is_data, rx_valid, n_reset_s;

   spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .io_sclk    (io_sclk),
      .io_sdin    (io_sdin),
      .io_cs      (io_cs),
      .io_dc      (io_dc),
      .io_reset   (io_reset),
      .data_byte  (rx_byte),
      .is_data    (rx_is_data),
      .byte_valid (rx_valid),
      .n_reset    (n_reset_s)
   );

   parse_state_e   state, state_nxt;
   logic [7:0]     opcode, opcode_nxt;
   logic [CW-1:0]  col, col_nxt, col_start, col_start_nxt, col_end, col_end_nxt;
   logic [PW-1:0]  page, page_nxt, page_start, page_start_nxt, page_end, page_end_nxt;
   logic [9:0]     fb_addr_nxt;
   logic [7:0]     fb_data_nxt, contrast_nxt;
   logic           fb_we_nxt, frame_done_nxt, display_on_nxt, invert_nxt;
   logic           entire_on_nxt, charge_pump_nxt;

   always_comb begin
      state_nxt       = state;
      opcode_nxt      = opcode;
      col_nxt         = col;
      page_nxt        = page;
      col_start_nxt   = col_start;
      col_end_nxt     = col_end;
      page_start_nxt  = page_start;
      page_end_nxt    = page_end;
      fb_addr_nxt     = fb_addr;
      fb_data_nxt     = fb_data;
      fb_we_nxt       = 1'b0;
      frame_done_nxt  = 1'b0;
      display_on_nxt  = display_on;
      contrast_nxt    = contrast;
      invert_nxt      = invert;
      entire_on_nxt   = entire_on;
      charge_pump_nxt = charge_pump;

      if (rx_valid && rx_is_data) begin
         // A data byte always lands in the framebuffer, even mid-command.
         state_nxt   = OP;
         fb_we_nxt   = 1'b1;
         fb_data_nxt = rx_byte;
         fb_addr_nxt = 10'(page) * 10'(COLS) + 10'(col);
         if (col == col_end) begin
            col_nxt = col_start;
            if (page == page_end) begin
               page_nxt       = page_start;
               frame_done_nxt = 1'b1;
            end else begin
               page_nxt = (page == PW'(PAGES-1)) ? '0 : page + PW'(1);
            end
         end else begin
            col_nxt = (col == CW'(COLS-1)) ? '0 : col + CW'(1);
         end
      end else if (rx_valid) begin
         unique case (state)
            OP: begin
               opcode_nxt = rx_byte;
               case (rx_byte)
                  OP_DISPLAY_OFF: display_on_nxt = 1'b0;
                  OP_DISPLAY_ON:  display_on_nxt = 1'b1;
                  OP_ENTIRE_OFF:  entire_on_nxt  = 1'b0;
                  OP_ENTIRE_ON:   entire_on_nxt  = 1'b1;
                  OP_NORMAL:      invert_nxt     = 1'b0;
                  OP_INVERT:      invert_nxt     = 1'b1;
                  OP_CONTRAST, OP_ADDR_MODE, OP_MUX_RATIO, OP_DISP_OFFSET,
                  OP_CLK_DIV, OP_PRECHARGE, OP_VCOMH, OP_CHARGE_PUMP,
                  OP_COL_ADDR, OP_PAGE_ADDR: state_nxt = ARG1;
                  default: ;
               endcase
            end
            ARG1: begin
               state_nxt = OP;
               case (opcode)
                  OP_CONTRAST:    contrast_nxt    = rx_byte;
                  OP_CHARGE_PUMP: charge_pump_nxt = rx_byte[2];
                  OP_COL_ADDR: begin
                     col_start_nxt = rx_byte[CW-1:0];
                     state_nxt     = ARG2;
                  end
                  OP_PAGE_ADDR: begin
                     page_start_nxt = rx_byte[PW-1:0];
                     state_nxt      = ARG2;
                  end
                  default: ;
               endcase
            end
            ARG2: begin
               state_nxt = OP;
               if (opcode == OP_COL_ADDR) begin
                  col_end_nxt = rx_byte[CW-1:0];
                  col_nxt     = col_start;
               end else if (opcode == OP_PAGE_ADDR) begin
                  page_end_nxt = rx_byte[PW-1:0];
                  page_nxt     = page_start;
               end
            end
            default: state_nxt = OP;
         endcase
      end

      if (!n_reset_s) begin
         state_nxt       = OP;
         opcode_nxt      = '0;
         col_nxt         = '0;
         page_nxt        = '0;
         col_start_nxt   = '0;
         col_end_nxt     = CW'(COLS-1);
         page_start_nxt  = '0;
         page_end_nxt    = PW'(PAGES-1);
         fb_addr_nxt     = '0;
         fb_data_nxt     = '0;
         fb_we_nxt       = 1'b0;
         frame_done_nxt  = 1'b0;
         display_on_nxt  = 1'b0;
         contrast_nxt    = CONTRAST_DEFAULT;
         invert_nxt      = 1'b0;
         entire_on_nxt   = 1'b0;
         charge_pump_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= OP;
         opcode      <= '0;
         col         <= '0;
         page        <= '0;
         col_start   <= '0;
         col_end     <= CW'(COLS-1);
         page_start  <= '0;
         page_end    <= PW'(PAGES-1);
         fb_addr     <= '0;
         fb_data     <= '0;
         fb_we       <= 1'b0;
         frame_done  <= 1'b0;
         display_on  <= 1'b0;
         contrast    <= CONTRAST_DEFAULT;
         invert      <= 1'b0;
         entire_on   <= 1'b0;
         charge_pump <= 1'b0;
      end else begin
         state       <= state_nxt;
         opcode      <= opcode_nxt;
         col         <= col_nxt;
         page        <= page_nxt;
         col_start   <= col_start_nxt;
         col_end     <= col_end_nxt;
         page_start  <= page_start_nxt;
         page_end    <= page_end_nxt;
         fb_addr     <= fb_addr_nxt;
         fb_data     <= fb_data_nxt;
         fb_we       <= fb_we_nxt;
         frame_done  <= frame_done_nxt;
         display_on  <= display_on_nxt;
         contrast    <= contrast_nxt;
         invert      <= invert_nxt;
         entire_on   <= entire_on_nxt;
         charge_pump <= charge_pump_nxt;
      end
   end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Drives the OLED SPI link bit by bit and compares display state and
// framebuffer writes against a byte-level model of the controller.
module tb_oled_spi_sink;

   localparam int COLS  = 128;
   localparam int PAGES = 8;

   logic clk = 1'b0, rst = 1'b1;
   logic io_sclk = 1'b1, io_sdin = 1'b0, io_cs = 1'b1, io_dc = 1'b0, io_reset = 1'b1;
   logic [9:0] fb_addr;
   logic [7:0] fb_data, contrast;
   logic       fb_we, frame_done, display_on, invert, entire_on, charge_pump;

   oled_spi_sink #(.SYNC_STAGES(2), .COLS(COLS), .PAGES(PAGES)) dut (
      .clk(clk), .rst(rst), .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs),
      .io_dc(io_dc), .io_reset(io_reset), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_we(fb_we), .frame_done(frame_done), .display_on(display_on),
      .contrast(contrast), .invert(invert), .entire_on(entire_on),
      .charge_pump(charge_pump)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0, stray_fd = 0, frames_seen = 0;
   logic [18:0] wq[$];

   always @(negedge clk) begin
      if (fb_we) wq.push_back({frame_done, fb_addr, fb_data});
      if (fb_we && frame_done) frames_seen++;
      if (frame_done && !fb_we) stray_fd++;
   end

   // Reference model: display registers plus pointer offsets inside the window.
   int m_cs, m_ce, m_ps, m_pe, m_ci, m_pi, m_pend, m_ai, m_frames = 0;
   logic [7:0] m_op, m_contrast;
   logic m_disp, m_inv, m_ent, m_cp;
   logic [9:0] last_addr;
   logic [7:0] last_data;
   logic last_fd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cs = 0; m_ce = COLS-1; m_ps = 0; m_pe = PAGES-1; m_ci = 0; m_pi = 0;
      m_pend = 0; m_ai = 0; m_op = 8'h00;
      m_contrast = 8'h7F; m_disp = 0; m_inv = 0; m_ent = 0; m_cp = 0;
   endtask

   function automatic int nargs(input logic [7:0] op);
      case (op)
         8'h21, 8'h22: return 2;
         8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: return 1;
         default: return 0;
      endcase
   endfunction

   // Returns {frame_done, addr} for the next write and advances the pointer.
   function automatic logic [10:0] model_write();
      int ncols, npages, addr;
      logic fd;
      ncols  = ((m_ce - m_cs + COLS) % COLS) + 1;
      npages = ((m_pe - m_ps + PAGES) % PAGES) + 1;
      addr   = ((m_ps + m_pi) % PAGES) * COLS + ((m_cs + m_ci) % COLS);
      fd = 1'b0;
      m_ci++;
      if (m_ci == ncols) begin
         m_ci = 0;
         m_pi++;
         if (m_pi == npages) begin
            m_pi = 0;
            fd = 1'b1;
         end
      end
      return {fd, 10'(addr)};
   endfunction

   task automatic model_cmd(input logic [7:0] b);
      if (m_pend > 0) begin
         if (m_op == 8'h81) m_contrast = b;
         if (m_op == 8'h8D) m_cp = b[2];
         if (m_op == 8'h21 && m_ai == 0) m_cs = int'(b) % COLS;
         if (m_op == 8'h21 && m_ai == 1) begin m_ce = int'(b) % COLS; m_ci = 0; end
         if (m_op == 8'h22 && m_ai == 0) m_ps = int'(b) % PAGES;
         if (m_op == 8'h22 && m_ai == 1) begin m_pe = int'(b) % PAGES; m_pi = 0; end
         m_ai++;
         m_pend--;
      end else begin
         m_op = b; m_ai = 0; m_pend = nargs(b);
         if (b == 8'hAE) m_disp = 0;
         if (b == 8'hAF) m_disp = 1;
         if (b == 8'hA4) m_ent = 0;
         if (b == 8'hA5) m_ent = 1;
         if (b == 8'hA6) m_inv = 0;
         if (b == 8'hA7) m_inv = 1;
      end
   endtask

   task automatic shift_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         io_sclk = 1'b0; io_sdin = b[i];
         #30;
         io_sclk = 1'b1;
         #30;
      end
   endtask

   task automatic send_byte(input logic dc, input logic [7:0] b);
      logic [10:0] exp;
      logic [18:0] got;
      io_cs = 1'b0; io_dc = dc;
      shift_bits(b, 8);
      if (dc) begin
         m_pend = 0;
         exp = model_write();
         if (exp[10]) m_frames++;
         for (int k = 0; k < 20 && wq.size() == 0; k++) @(negedge clk);
         chk("we_seen", 32'(wq.size() != 0), 32'd1);
         if (wq.size() != 0) begin
            got = wq.pop_front();
            chk("wr_addr", 32'(got[17:8]), 32'(exp[9:0]));
            chk("wr_data", 32'(got[7:0]), 32'(b));
            chk("wr_frame", 32'(got[18]), 32'(exp[10]));
            last_addr = got[17:8]; last_data = got[7:0]; last_fd = got[18];
         end
      end else begin
         model_cmd(b);
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, "_disp"}, 32'(display_on), 32'(m_disp));
      chk({tag, "_contrast"}, 32'(contrast), 32'(m_contrast));
      chk({tag, "_invert"}, 32'(invert), 32'(m_inv));
      chk({tag, "_entire"}, 32'(entire_on), 32'(m_ent));
      chk({tag, "_cp"}, 32'(charge_pump), 32'(m_cp));
   endtask

   logic [7:0] pwr_seq[23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
                               8'hA1, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                               8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
   logic [7:0] win_seq[6] = '{8'h21, 8'h10, 8'h13, 8'h22, 8'h02, 8'h03};
   int         win_exp[10] = '{272, 273, 274, 275, 400, 401, 402, 403, 272, 273};
   logic [7:0] singles[10] = '{8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                               8'hC8, 8'h40, 8'hA1, 8'hE3};

   initial begin
      int r, a, b;
      model_reset();
      #20 rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_we", 32'(fb_we), 32'd0);
      chk("rst_addr", 32'(fb_addr), 32'd0);
      chk("rst_data", 32'(fb_data), 32'd0);
      chk("rst_frame", 32'(frame_done), 32'd0);
      chk_regs("rst");

      foreach (pwr_seq[i]) send_byte(1'b0, pwr_seq[i]);
      chk_regs("pwr");
      chk("pwr_disp_on", 32'(display_on), 32'd1);
      chk("pwr_cp_on", 32'(charge_pump), 32'd1);
      chk("pwr_no_writes", 32'(wq.size()), 32'd0);

      for (int i = 0; i < 1024; i++) begin
         send_byte(1'b1, 8'(i));
         if (i == 1022) chk("fill_1022_nofd", 32'(last_fd), 32'd0);
      end
      chk("fill_last_addr", 32'(last_addr), 32'd1023);
      chk("fill_last_fd", 32'(last_fd), 32'd1);
      chk("fill_frames", 32'(frames_seen), 32'd1);
      send_byte(1'b1, 8'hC3);
      chk("fill_wrap_addr", 32'(last_addr), 32'd0);

      foreach (win_seq[i]) send_byte(1'b0, win_seq[i]);
      for (int i = 0; i < 10; i++) begin
         send_byte(1'b1, 8'($urandom));
         chk("win_addr", 32'(last_addr), 32'(win_exp[i]));
         chk("win_fd", 32'(last_fd), 32'(i == 7));
      end

      send_byte(1'b0, 8'h81);
      io_cs = 1'b0; io_dc = 1'b0;
      shift_bits(8'hFF, 5);
      io_cs = 1'b1;
      repeat (4) @(negedge clk);
      send_byte(1'b0, 8'h40);
      chk("partial_contrast", 32'(contrast), 32'h40);
      chk_regs("partial");

      send_byte(1'b0, 8'h81);
      send_byte(1'b1, 8'h55);
      chk("abort_contrast", 32'(contrast), 32'h40);
      chk("abort_data", 32'(last_data), 32'h55);
      send_byte(1'b0, 8'hA7);
      chk("abort_invert", 32'(invert), 32'd1);

      send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h7F);
      send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h07);
      for (int i = 0; i < 5; i++) send_byte(1'b1, 8'(8'hA0 + i));
      send_byte(1'b0, 8'h81); send_byte(1'b0, 8'h20);
      chk("iores_pre_contrast", 32'(contrast), 32'h20);
      io_reset = 1'b0;
      repeat (4) @(negedge clk);
      io_reset = 1'b1;
      repeat (4) @(negedge clk);
      model_reset();
      chk("iores_contrast", 32'(contrast), 32'h7F);
      chk_regs("iores");
      send_byte(1'b1, 8'h3C);
      chk("iores_addr", 32'(last_addr), 32'd0);

      send_byte(1'b0, 8'hAF);
      send_byte(1'b1, 8'h11);
      send_byte(1'b1, 8'hA5);
      io_cs = 1'b0; io_dc = 1'b1;
      shift_bits(8'hFF, 3);
      io_sclk = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstmid_disp", 32'(display_on), 32'd0);
      chk("rstmid_addr", 32'(fb_addr), 32'd0);
      chk("rstmid_data", 32'(fb_data), 32'd0);
      chk("rstmid_contrast", 32'(contrast), 32'h7F);
      chk("rstmid_invert", 32'(invert), 32'd0);
      #9;
      io_sclk = 1'b1; io_cs = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      send_byte(1'b1, 8'h77);
      chk("rstmid_next_addr", 32'(last_addr), 32'd0);
      chk("rstmid_next_data", 32'(last_data), 32'h77);

      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            send_byte(1'b1, 8'($urandom));
         end else if (r == 6) begin
            send_byte(1'b0, singles[$urandom_range(0, 9)]);
         end else if (r == 7) begin
            send_byte(1'b0, 8'h81); send_byte(1'b0, 8'($urandom));
         end else if (r == 8) begin
            send_byte(1'b0, 8'h8D); send_byte(1'b0, 8'($urandom));
         end else begin
            a = $urandom_range(118, 127);
            b = (a + $urandom_range(0, 12)) % COLS;
            send_byte(1'b0, 8'h21);
            send_byte(1'b0, 8'(($urandom_range(0, 1) << 7) | a));
            send_byte(1'b0, 8'(($urandom_range(0, 1) << 7) | b));
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(0, 2)) % PAGES;
            send_byte(1'b0, 8'h22);
            send_byte(1'b0, 8'(($urandom_range(0, 31) << 3) | a));
            send_byte(1'b0, 8'(($urandom_range(0, 31) << 3) | b));
         end
         chk_regs("rand");
      end

      repeat (10) @(negedge clk);
      chk("stray_frame_done", 32'(stray_fd), 32'd0);
      chk("frame_count", 32'(frames_seen), 32'(m_frames));
      chk("extra_writes", 32'(wq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- SPI receiver that emulates the SSD1306-style controller end of the 4-wire OLED link: io_sclk, io_sdin, io_cs, io_dc, io_reset.
- Deserialises bytes and decodes command bytes into a small display-state register set.
- Writes data bytes into an external 1024-byte framebuffer using the horizontal addressing window.
- Used in simulation as a display model, and on hardware to mirror the OLED image to a second output path.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on io_sclk/io_sdin/io_cs/io_dc/io_reset (minimum 2).
- COLS, 128, display columns.
- PAGES, 8, display pages (8 rows each); fb_addr = page*COLS + col.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- io_sclk  in  1  SPI clock from the master; idles high; data is sampled on its rising edge.
- io_sdin  in  1  SPI data, MSB first.
- io_cs  in  1  chip select, active low.
- io_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- io_reset  in  1  display reset, active low.
- fb_addr  out  10  framebuffer write address.
- fb_data  out  8  framebuffer write byte.
- fb_we  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse when the write pointer wraps to the window start.
- display_on  out  1  set by 0xAF, cleared by 0xAE.
- contrast  out  8  argument of 0x81.
- invert  out  1  0xA6 → 0, 0xA7 → 1.
- entire_on  out  1  0xA4 → 0, 0xA5 → 1.
- charge_pump  out  1  bit 2 of the 0x8D argument.

Behaviour:
- Reset values (rst high, asynchronous): fb_we=0, frame_done=0, fb_addr=0, fb_data=0, display_on=0, contrast=0x7F, invert=0, entire_on=0, charge_pump=0.
  - Internal: col=0, page=0, col window 0..127, page window 0..7, bit count 0, parser in OP.
- All inputs pass through SYNC_STAGES flops. A rising edge is detected from the last two synchronised io_sclk samples.
- Clock ratio: clk must give ≥2 cycles per io_sclk high phase and per low phase. Slower edges are out of scope and are not detected.
- Shift register behaviour:
  - While synchronised cs=1, the bit count is held at 0 and any partial byte is discarded.
  - While cs=0, each rising edge shifts in sdin. On the 8th edge, the byte and the synchronised dc are registered and the bit count returns to 0.
  - cs may stay low across bytes.
- Data byte (dc=1):
  - fb_data=byte, fb_addr=page*COLS+col, fb_we=1 for exactly one cycle.
  - Latency: fb_we is high on the clk edge SYNC_STAGES+1 edges after the edge that first samples io_sclk high.
  - Pointer advance: col++. If col would exceed col_end, col=col_start and page++. If page would exceed page_end, page=page_start and frame_done pulses in the same cycle as fb_we.
- Command parser states:
  - OP: decodes the opcode.
    - Single-byte opcodes: AE, AF, A4, A5, A6, A7 update their outputs.
    - One-argument opcodes 81, 20, A8, D3, D5, D9, DB, 8D go to ARG1.
    - Two-argument opcodes 21 (column range) and 22 (page range) go to ARG1.
    - Any other opcode is ignored and the parser stays in OP.
  - ARG1:
    - 81 → contrast.
    - 8D → charge_pump = arg[2].
    - 20, A8, D3, D5, D9, DB: argument consumed and discarded.
    - 21 → col_start = arg[6:0]; 22 → page_start = arg[2:0]; both go to ARG2.
    - All other one-argument opcodes return to OP.
  - ARG2:
    - 21 → col_end = arg[6:0], col = col_start.
    - 22 → page_end = arg[2:0], page = page_start.
    - Returns to OP.
- A data byte arriving while the parser is in ARG1/ARG2 aborts the parse (parser → OP) and is still written to the framebuffer.
- Start greater than end is legal: the pointer advances from start to its wrap limit (127 for col, 7 for page), wraps to 0, and continues counting up to end.
- Synchronised io_reset=0 synchronously forces every reset value, holds the parser in OP, and ignores SPI traffic. Normal operation resumes on the first cycle after it returns to 1.
- rst asserted mid-byte: the partial byte is lost and all state returns to reset values immediately.

Decomposition:
- Package oled_pkg:
  - Opcode constants (OP_DISPLAY_OFF=8'hAE … OP_PAGE_ADDR=8'h22).
  - Reset defaults (CONTRAST_DEFAULT=8'h7F).
  - Parser state enum {OP, ARG1, ARG2}.
- Sub-module spi_byte_rx:
  - Covers synchronisers, edge detect, and the shift register.
  - Outputs byte[7:0], is_data, byte_valid (1-cycle), and the synchronised n_reset.
- The top level holds the parser, the address window, and the pointer logic.

Test Plan:
- Power-up command sequence AE,81,7F,A6,20,00,C8,40,A1,A8,3F,D3,00,D5,80,D9,22,DB,20,8D,14,A4,AF with dc=0 → display_on=1, contrast=0x7F, charge_pump=1, invert=0, no fb_we pulses.
- 1024 data bytes carrying values i[7:0] → fb_we pulses 1024 times with fb_addr=i and fb_data=i[7:0]; frame_done pulses once, on byte 1023; the next byte goes to address 0.
- Commands 21,10,13,22,02,03 then 10 data bytes → addresses 272,273,274,275,400,401,402,403,272,273 in that order; frame_done pulses on the 8th byte.
- Command 81, then cs high after 5 bits, then a full byte 0x40 → the partial byte is discarded and contrast=0x40.
- Command 81 followed by a data byte 0x55 → contrast unchanged; 0x55 written at the current pointer; parser back in OP (a following A7 sets invert=1).
- io_reset held low for 4 cycles after contrast=0x20 and col=5 → contrast=0x7F and the pointer returns to 0. Repeat with rst asserted mid-byte → all outputs take reset values in the same cycle.
